// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-level FSM encoding and default baud settings.
// Both the transmitter and the future receiver import this package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_t;

  localparam int DEFAULT_CLK_HZ       = 100_000_000;
  localparam int DEFAULT_BAUD         = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BAUD;
  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_STOP_BITS    = 1;

  // Integer division truncates, matching how the board's 868 was derived.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT clocks.
// Holding clear keeps the count at zero so the next period starts aligned.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == TERM) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word, then shifts it out as
// start bit, WIDTH data bits LSB first, and STOP_BITS stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_rd_cs,
  output logic                   fifo_rd_en,
  output logic                   tx,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frames_sent
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);
  localparam logic STOP_LAST = (STOP_BITS > 1) ? 1'b1 : 1'b0;

  uart_state_t state, state_next;

  logic [WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0] bit_idx;
  logic             stop_idx;
  logic             baud_clear;
  logic             baud_tick;
  logic             last_stop;

  // The bit timer only runs inside a frame so START always gets a full period.
  assign baud_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);
  assign last_stop  = (state == ST_STOP) && baud_tick && (stop_idx == STOP_LAST);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // fifo_empty lags the FIFO by a cycle, so it is only trusted in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable && !fifo_empty) state_next = ST_POP;
      ST_POP:   state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_START;
      ST_START: if (baud_tick) state_next = ST_DATA;
      ST_DATA:  if (baud_tick && (bit_idx == LAST_BIT)) state_next = ST_STOP;
      ST_STOP:  if (last_stop) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          shift_reg <= fifo_data;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            stop_idx <= ~stop_idx;
          end
          if (last_stop) begin
            frames_sent <= frames_sent + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line level is a pure decode of state and the shift register LSB.
  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_reg[0];
      default:  tx = 1'b1;
    endcase
  end

  assign fifo_rd_en = (state == ST_POP);
  assign fifo_rd_cs = fifo_rd_en;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a lagging-empty FIFO model and
// a line-level reference that derives each expected tx bit from frame arithmetic.
module tb_fifo_uart_tx;

  localparam int WIDTH       = 8;
  localparam int CPB         = 4;
  localparam int STOP_BITS   = 1;
  localparam int COUNT_WIDTH = 2;
  localparam int FRAME_CYC   = (1 + WIDTH + STOP_BITS) * CPB;
  localparam int COUNT_MOD   = 1 << COUNT_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   enable = 1'b0;
  logic                   fifo_empty = 1'b1;
  logic [WIDTH-1:0]       fifo_data = '0;
  logic                   fifo_rd_cs;
  logic                   fifo_rd_en;
  logic                   tx;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] frames_sent;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .WIDTH       (WIDTH),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_cs (fifo_rd_cs),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  // FIFO model: data appears the cycle after a pop, empty reflects the old count.
  always @(posedge clk) begin : fifo_model
    bit was_empty;
    was_empty = (fifo_q.size() == 0);
    if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= was_empty;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Waits for a pop, then checks every line cycle of the frame against the
  // bit position implied by its offset from the first START cycle.
  task automatic check_frame(input int expect_wait, input int drop_en_at);
    int waited;
    int bit_no;
    logic [WIDTH-1:0] b;
    logic exp_tx;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!fifo_rd_en && waited < 200);
    if (!fifo_rd_en) begin
      check_output("pop_timeout", 32'd0, 32'd1);
      return;
    end
    if (expect_wait >= 0) check_output("pop_latency", waited, expect_wait);
    check_output("rd_cs", fifo_rd_cs, 1);
    if (exp_q.size() == 0) begin
      check_output("unexpected_pop", 32'd1, 32'd0);
      return;
    end
    b = exp_q.pop_front();
    @(negedge clk);
    check_output("load_rd_en", fifo_rd_en, 0);
    check_output("load_tx", tx, 1);
    check_output("load_busy", busy, 1);
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      bit_no = c / CPB;
      if (bit_no == 0)          exp_tx = 1'b0;
      else if (bit_no <= WIDTH) exp_tx = b[bit_no-1];
      else                      exp_tx = 1'b1;
      check_output("frame_tx", tx, exp_tx);
      check_output("frame_busy", busy, 1);
      check_output("frame_rd_en", fifo_rd_en, 0);
      if (c == drop_en_at) enable = 1'b0;
    end
    @(negedge clk);
    exp_frames = (exp_frames + 1) % COUNT_MOD;
    check_output("idle_busy", busy, 0);
    check_output("idle_tx", tx, 1);
    check_output("frames_sent", frames_sent, exp_frames);
  endtask

  task automatic expect_no_pop(input string tag, input int cycles);
    int pops;
    pops = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (fifo_rd_en) pops++;
    end
    check_output(tag, pops, 0);
  endtask

  initial begin
    int waited;
    int n;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_tx", tx, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_rd_en", fifo_rd_en, 0);
    check_output("reset_rd_cs", fifo_rd_cs, 0);
    check_output("reset_frames", frames_sent, 0);
    rst = 1'b0;

    // Empty FIFO with enable high must leave the line idle.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_output("idle_tx_hold", tx, 1);
      check_output("idle_busy_hold", busy, 0);
      check_output("idle_rd_en_hold", fifo_rd_en, 0);
      check_output("idle_frames_hold", frames_sent, 0);
    end

    apply_stimulus(8'hA5);
    check_frame(-1, -1);

    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    check_frame(-1, -1);
    check_frame(1, -1);
    expect_no_pop("no_third_pop", 30);

    // Enable drops during DATA bit 2: frame finishes, next byte waits.
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    check_frame(-1, 3 * CPB);
    expect_no_pop("no_pop_disabled", 20);
    enable = 1'b1;
    check_frame(1, -1);

    // Reset during DATA bit 3 discards the popped byte.
    apply_stimulus(8'h3C);
    apply_stimulus(8'h5A);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!fifo_rd_en && waited < 200);
    check_output("rst_test_pop", fifo_rd_en, 1);
    void'(exp_q.pop_front());
    repeat (1 + CPB + 3 * CPB + 1) @(negedge clk);
    check_output("pre_reset_tx_bit3", tx, 1);
    check_output("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_reset_tx", tx, 1);
    check_output("mid_reset_busy", busy, 0);
    check_output("mid_reset_rd_en", fifo_rd_en, 0);
    check_output("mid_reset_frames", frames_sent, 0);
    rst = 1'b0;
    exp_frames = 0;
    check_frame(-1, -1);

    // Four more frames carry the 2-bit counter through its wrap.
    for (int i = 0; i < 4; i++) apply_stimulus(WIDTH'($urandom));
    for (int i = 0; i < 4; i++) check_frame(i == 0 ? -1 : 1, -1);

    // Random bursts with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) apply_stimulus(WIDTH'($urandom));
      for (int i = 0; i < n; i++) check_frame(i == 0 ? -1 : 1, -1);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    expect_no_pop("final_no_pop", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
